// File: rtl/axi_wr_arbiter_rr_pkg.sv
// axi_arb_pkg: FSM states, arbitration modes and index helper shared by the write arbiter
package axi_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_RESP} arb_state_e;
    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;
    function automatic int onehot_to_idx(input logic [15:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) r = oh[i] ? (r | i) : r;
        return r;
    endfunction
endpackage

// File: rtl/axi_wr_arbiter_rr_if.sv
// axi_wr_arbiter_rr_if: per-master AW/W/B handshake view plus the arbiter's grant outputs
interface axi_wr_arbiter_rr_if #(
    parameter int NUM_MASTERS = 4,
    parameter int BEAT_CNT_W  = 8
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    logic [NUM_MASTERS-1:0] m_awvalid;
    logic [NUM_MASTERS-1:0] m_wvalid;
    logic [NUM_MASTERS-1:0] m_wlast;
    logic [NUM_MASTERS-1:0] m_bready;
    logic                   s_awready;
    logic                   s_wready;
    logic                   s_bvalid;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   busy;
    logic [BEAT_CNT_W-1:0]  beat_cnt;
    modport master (
        output m_awvalid, m_wvalid, m_wlast, m_bready, s_awready, s_wready, s_bvalid,
        input  grant, grant_idx, busy, beat_cnt
    );
    modport slave (
        input  m_awvalid, m_wvalid, m_wlast, m_bready, s_awready, s_wready, s_bvalid,
        output grant, grant_idx, busy, beat_cnt
    );
endinterface

// File: rtl/axi_wr_arbiter_rr_rr_pick.sv
// rr_pick: combinational winner search starting just above ptr; fixed mode starts above the top index
module rr_pick
    import axi_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    localparam int IDX_W = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       ptr_i,
    input  logic                   fixed_i,
    output logic [NUM_MASTERS-1:0] win_o,
    output logic [IDX_W-1:0]       idx_o,
    output logic                   any_o
);
    logic [15:0]      win16;
    logic [IDX_W-1:0] j;
    logic             found;
    int               base;
    always_comb begin
        win_o = '0;
        found = 1'b0;
        j     = '0;
        base  = fixed_i ? NUM_MASTERS - 1 : int'(ptr_i);
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            j = IDX_W'((base + i) % NUM_MASTERS);
            if (!found && req_i[j]) begin
                win_o[j] = 1'b1;
                found    = 1'b1;
            end
        end
        win16                  = '0;
        win16[NUM_MASTERS-1:0] = win_o;
        idx_o = IDX_W'(onehot_to_idx(win16));
        any_o = |req_i;
    end
endmodule

// File: rtl/axi_wr_arbiter_rr.sv
// axi_wr_arbiter_rr: grants one master the shared AW/W/B channels from arbitration until its B handshake
module axi_wr_arbiter_rr
    import axi_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int PRIO_MODE   = PRIO_RR,
    parameter int BEAT_CNT_W  = 8
) (
    input  logic               aclk,
    input  logic               aresetn,
    axi_wr_arbiter_rr_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    arb_state_e             state_q;
    logic [NUM_MASTERS-1:0] grant_q, win;
    logic [IDX_W-1:0]       gidx_q, rr_ptr_q, win_idx;
    logic [BEAT_CNT_W-1:0]  beat_q;
    logic                   busy_q, aw_done_q, w_done_q, any_req;
    logic                   aw_hs, w_hs, aw_d, w_d;
    rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
        .req_i   (bus.m_awvalid),
        .ptr_i   (rr_ptr_q),
        .fixed_i (PRIO_MODE == PRIO_FIXED),
        .win_o   (win),
        .idx_o   (win_idx),
        .any_o   (any_req)
    );
    // W beats after the last one are ignored, so beat_cnt freezes once w_done is set
    always_comb begin
        aw_hs = bus.m_awvalid[gidx_q] & bus.s_awready;
        w_hs  = bus.m_wvalid[gidx_q] & bus.s_wready & ~w_done_q;
        aw_d  = aw_done_q | aw_hs;
        w_d   = w_done_q | (w_hs & bus.m_wlast[gidx_q]);
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            busy_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            beat_q    <= '0;
            rr_ptr_q  <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    beat_q    <= '0;
                    if (any_req) begin
                        state_q <= ARB_XFER;
                        grant_q <= win;
                        gidx_q  <= win_idx;
                        busy_q  <= 1'b1;
                    end
                end
                ARB_XFER: begin
                    aw_done_q <= aw_d;
                    w_done_q  <= w_d;
                    if (w_hs && beat_q != '1) beat_q <= beat_q + 1'b1;
                    if (aw_d && w_d) state_q <= ARB_RESP;
                end
                ARB_RESP: begin
                    if (bus.s_bvalid && bus.m_bready[gidx_q]) begin
                        state_q  <= ARB_IDLE;
                        rr_ptr_q <= gidx_q;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end
    assign bus.grant     = grant_q;
    assign bus.grant_idx = gidx_q;
    assign bus.busy      = busy_q;
    assign bus.beat_cnt  = beat_q;
endmodule

// File: tb/tb_axi_wr_arbiter_rr.sv
// tb_axi_wr_arbiter_rr: vector table plus scoreboard for round-robin and fixed-priority arbiters
module tb_axi_wr_arbiter_rr;
    typedef struct {
        int d;
        logic [3:0] aw, wv, wl, br;
        logic [2:0] rdy;
        logic [3:0] g;
        logic b;
        logic [7:0] bc;
    } vec_t;
    typedef struct {
        int d;
        logic [3:0] g;
        logic b;
        logic [7:0] bc;
        int n;
    } exp_t;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    exp_t sb[$];
    int n1;
    always #5 aclk = ~aclk;
    axi_wr_arbiter_rr_if #(.NUM_MASTERS(4), .BEAT_CNT_W(8)) bus_rr();
    axi_wr_arbiter_rr_if #(.NUM_MASTERS(4), .BEAT_CNT_W(8)) bus_fx();
    axi_wr_arbiter_rr #(.NUM_MASTERS(4), .PRIO_MODE(0), .BEAT_CNT_W(8)) dut_rr (
        .aclk(aclk), .aresetn(aresetn), .bus(bus_rr));
    axi_wr_arbiter_rr #(.NUM_MASTERS(4), .PRIO_MODE(1), .BEAT_CNT_W(8)) dut_fx (
        .aclk(aclk), .aresetn(aresetn), .bus(bus_fx));
    function automatic vec_t mk(input int d, input logic [3:0] aw, wv, wl, br,
                                input logic [2:0] rdy, input logic [3:0] g,
                                input logic b, input logic [7:0] bc);
        vec_t v;
        v.d = d; v.aw = aw; v.wv = wv; v.wl = wl; v.br = br;
        v.rdy = rdy; v.g = g; v.b = b; v.bc = bc;
        return v;
    endfunction
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic cmp(input exp_t e);
        logic [3:0] g;
        logic [1:0] gi, ei;
        logic b;
        logic [7:0] bc;
        g  = e.d != 0 ? bus_fx.grant : bus_rr.grant;
        gi = e.d != 0 ? bus_fx.grant_idx : bus_rr.grant_idx;
        b  = e.d != 0 ? bus_fx.busy : bus_rr.busy;
        bc = e.d != 0 ? bus_fx.beat_cnt : bus_rr.beat_cnt;
        ei = 2'd0;
        for (int i = 0; i < 4; i++) if (e.g[i]) ei = 2'(i);
        chk($sformatf("v%0d.d%0d.grant", e.n, e.d), {4'b0, g}, {4'b0, e.g});
        chk($sformatf("v%0d.d%0d.busy", e.n, e.d), {7'b0, b}, {7'b0, e.b});
        chk($sformatf("v%0d.d%0d.beat_cnt", e.n, e.d), bc, e.bc);
        if (e.b) chk($sformatf("v%0d.d%0d.grant_idx", e.n, e.d), {6'b0, gi}, {6'b0, ei});
    endtask
    task automatic apply(input vec_t v, input int n);
        if (v.d == 0) begin
            bus_rr.m_awvalid = v.aw; bus_rr.m_wvalid = v.wv; bus_rr.m_wlast = v.wl;
            bus_rr.m_bready = v.br;
            {bus_rr.s_awready, bus_rr.s_wready, bus_rr.s_bvalid} = v.rdy;
        end else begin
            bus_fx.m_awvalid = v.aw; bus_fx.m_wvalid = v.wv; bus_fx.m_wlast = v.wl;
            bus_fx.m_bready = v.br;
            {bus_fx.s_awready, bus_fx.s_wready, bus_fx.s_bvalid} = v.rdy;
        end
        sb.push_back('{v.d, v.g, v.b, v.bc, n});
        @(posedge aclk);
        #1;
        while (sb.size() > 0) cmp(sb.pop_front());
    endtask
    initial begin
        logic [3:0] m;
        {bus_rr.m_awvalid, bus_rr.m_wvalid, bus_rr.m_wlast, bus_rr.m_bready} = '0;
        {bus_rr.s_awready, bus_rr.s_wready, bus_rr.s_bvalid} = '0;
        {bus_fx.m_awvalid, bus_fx.m_wvalid, bus_fx.m_wlast, bus_fx.m_bready} = '0;
        {bus_fx.s_awready, bus_fx.s_wready, bus_fx.s_bvalid} = '0;
        // round-robin rotation with single-beat writes and always-ready slave
        for (int k = 0; k < 5; k++) begin
            m = 4'b0001 << (k % 4);
            tbl.push_back(mk(0, 4'hF, 4'hF, 4'hF, 4'hF, 3'b111, m, 1'b1, 8'd0));
            tbl.push_back(mk(0, 4'hF, 4'hF, 4'hF, 4'hF, 3'b111, m, 1'b1, 8'd1));
            tbl.push_back(mk(0, 4'hF, 4'hF, 4'hF, 4'hF, 3'b111, 4'h0, 1'b0, 8'd1));
        end
        // m2: four W beats before AW, an ignored extra beat, then AW and release
        tbl.push_back(mk(0, 4'h4, 4'h0, 4'h0, 4'h4, 3'b001, 4'h4, 1'b1, 8'd0));
        for (int b = 1; b <= 4; b++)
            tbl.push_back(mk(0, 4'h4, 4'h4, b == 4 ? 4'h4 : 4'h0, 4'h4, 3'b011, 4'h4, 1'b1, 8'(b)));
        tbl.push_back(mk(0, 4'h4, 4'h4, 4'h4, 4'h4, 3'b011, 4'h4, 1'b1, 8'd4));
        tbl.push_back(mk(0, 4'h4, 4'h0, 4'h0, 4'h4, 3'b101, 4'h4, 1'b1, 8'd4));
        tbl.push_back(mk(0, 4'h4, 4'h0, 4'h0, 4'h4, 3'b001, 4'h0, 1'b0, 8'd4));
        tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 3'b000, 4'h0, 1'b0, 8'd0));
        // m3 with B back-pressure for five cycles; other masters' bready must not release
        tbl.push_back(mk(0, 4'h8, 4'h8, 4'h8, 4'h0, 3'b111, 4'h8, 1'b1, 8'd0));
        tbl.push_back(mk(0, 4'h8, 4'h8, 4'h8, 4'h0, 3'b111, 4'h8, 1'b1, 8'd1));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 4'h8, 4'h8, 4'h8, 4'h7, 3'b111, 4'h8, 1'b1, 8'd1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h8, 3'b111, 4'h0, 1'b0, 8'd1));
        // m1 completes, then m2 starts and is interrupted by reset
        tbl.push_back(mk(0, 4'h2, 4'h2, 4'h2, 4'hF, 3'b111, 4'h2, 1'b1, 8'd0));
        tbl.push_back(mk(0, 4'h2, 4'h2, 4'h2, 4'hF, 3'b111, 4'h2, 1'b1, 8'd1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'hF, 3'b111, 4'h0, 1'b0, 8'd1));
        tbl.push_back(mk(0, 4'h4, 4'h4, 4'h0, 4'h0, 3'b010, 4'h4, 1'b1, 8'd0));
        tbl.push_back(mk(0, 4'h4, 4'h4, 4'h0, 4'h0, 3'b010, 4'h4, 1'b1, 8'd1));
        tbl.push_back(mk(0, 4'h4, 4'h4, 4'h0, 4'h0, 3'b010, 4'h4, 1'b1, 8'd2));
        n1 = tbl.size();
        tbl.push_back(mk(0, 4'hF, 4'hF, 4'hF, 4'hF, 3'b111, 4'h1, 1'b1, 8'd0));
        // fixed priority: m1 wins repeatedly over m3 until it stops requesting
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(mk(1, 4'hA, 4'hA, 4'hA, 4'hF, 3'b111, 4'h2, 1'b1, 8'd0));
            tbl.push_back(mk(1, 4'hA, 4'hA, 4'hA, 4'hF, 3'b111, 4'h2, 1'b1, 8'd1));
            tbl.push_back(mk(1, 4'hA, 4'hA, 4'hA, 4'hF, 3'b111, 4'h0, 1'b0, 8'd1));
        end
        tbl.push_back(mk(1, 4'h8, 4'h8, 4'h8, 4'hF, 3'b111, 4'h8, 1'b1, 8'd0));
        tbl.push_back(mk(1, 4'h8, 4'h8, 4'h8, 4'hF, 3'b111, 4'h8, 1'b1, 8'd1));
        tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'hF, 3'b111, 4'h0, 1'b0, 8'd1));
        repeat (3) @(posedge aclk);
        #1;
        cmp('{0, 4'h0, 1'b0, 8'd0, -1});
        cmp('{1, 4'h0, 1'b0, 8'd0, -1});
        aresetn = 1'b1;
        for (int i = 0; i < n1; i++) apply(tbl[i], i);
        // asynchronous reset in the middle of XFER must clear outputs without a clock edge
        #2;
        aresetn = 1'b0;
        #1;
        cmp('{0, 4'h0, 1'b0, 8'd0, -2});
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        for (int i = n1; i < tbl.size(); i++) apply(tbl[i], i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
